// File: rtl/tetris_input_if.sv
// tetris_input_if: player-input bundle between the board pins/ADC and the input conditioner.
interface tetris_input_if;
  logic [11:0] adc_value;
  logic        s1;
  logic        s2;
  logic        move_left;
  logic        move_right;
  logic        move_down;
  logic        rotate;
  logic        tilt_active;
  modport master (output adc_value, s1, s2, input move_left, move_right, move_down, rotate, tilt_active);
  modport slave  (input adc_value, s1, s2, output move_left, move_right, move_down, rotate, tilt_active);
endinterface

// File: rtl/tetris_input_ctrl.sv
// tetris_input_ctrl: tilt hysteresis FSM with DAS/ARR auto-repeat, and debounced S1/S2 into one-cycle pulses.
// Define SOFT_DROP_REPEAT_EN to auto-repeat move_down while S2 stays pressed.
module tetris_input_ctrl #(
  parameter int unsigned THRESH_HI  = 1815,
  parameter int unsigned THRESH_LO  = 1485,
  parameter int unsigned HYST       = 40,
  parameter int unsigned DB_CYCLES  = 1000000,
  parameter int unsigned DAS_CYCLES = 8000000,
  parameter int unsigned ARR_CYCLES = 2500000
) (
  input logic           clk,
  input logic           reset_n,
  tetris_input_if.slave io
);
  localparam int unsigned TW = $clog2((DAS_CYCLES > ARR_CYCLES ? DAS_CYCLES : ARR_CYCLES) + 1);
  localparam int unsigned DW = $clog2(DB_CYCLES + 1);
  localparam logic [11:0] HI      = 12'(THRESH_HI);
  localparam logic [11:0] LO      = 12'(THRESH_LO);
  localparam logic [11:0] HI_EXIT = 12'(THRESH_HI - HYST);
  localparam logic [11:0] LO_EXIT = 12'(THRESH_LO + HYST);
  localparam logic [11:0] ADC_MID = 12'((THRESH_HI + THRESH_LO) / 2);
  localparam logic [TW-1:0] DAS_LIM = TW'(DAS_CYCLES - 1);
  localparam logic [TW-1:0] ARR_LIM = TW'(ARR_CYCLES - 1);
  localparam logic [DW-1:0] DB_LIM  = DW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {CENTER, LEFT, RIGHT} tilt_e;

  tilt_e         state_q, state_d;
  logic [11:0]   adc_q;
  logic [TW-1:0] tmr_q;
  logic          das_q, fire_q, left_q, right_q, active_q, tick;

  always_comb begin
    case (state_q)
      RIGHT:   state_d = adc_q < LO ? LEFT : adc_q < HI_EXIT ? CENTER : RIGHT;
      LEFT:    state_d = adc_q > HI ? RIGHT : adc_q > LO_EXIT ? CENTER : LEFT;
      default: state_d = adc_q > HI ? RIGHT : adc_q < LO ? LEFT : CENTER;
    endcase
  end

  assign tick = tmr_q == (das_q ? ARR_LIM : DAS_LIM);

  // adc_q resets to mid-scale so the FSM stays CENTER until a real sample arrives
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      adc_q    <= ADC_MID;
      state_q  <= CENTER;
      tmr_q    <= '0;
      das_q    <= 1'b0;
      fire_q   <= 1'b0;
      left_q   <= 1'b0;
      right_q  <= 1'b0;
      active_q <= 1'b0;
    end else begin
      adc_q    <= io.adc_value;
      state_q  <= state_d;
      active_q <= state_q != CENTER;
      left_q   <= fire_q && state_q == LEFT;
      right_q  <= fire_q && state_q == RIGHT;
      if (state_d != state_q) begin
        tmr_q  <= '0;
        das_q  <= 1'b0;
        fire_q <= state_d != CENTER;
      end else if (state_q == CENTER || tick) begin
        tmr_q  <= '0;
        das_q  <= state_q != CENTER;
        fire_q <= state_q != CENTER;
      end else begin
        tmr_q  <= tmr_q + 1'b1;
        fire_q <= 1'b0;
      end
    end
  end

  logic [1:0]         meta_q, sync_q, db_q, flip, press;
  logic [1:0][DW-1:0] cnt_q;
  logic               rot_q, down_q, rep;

  for (genvar i = 0; i < 2; i++) begin : g_btn
    assign flip[i]  = sync_q[i] != db_q[i] && cnt_q[i] == DB_LIM;
    assign press[i] = flip[i] && !sync_q[i];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= '1;
      sync_q <= '1;
      db_q   <= '1;
      cnt_q  <= '0;
      rot_q  <= 1'b0;
      down_q <= 1'b0;
    end else begin
      meta_q <= {io.s2, io.s1};
      sync_q <= meta_q;
      db_q   <= db_q ^ flip;
      for (int b = 0; b < 2; b++)
        cnt_q[b] <= (sync_q[b] == db_q[b] || flip[b]) ? '0 : cnt_q[b] + 1'b1;
      rot_q  <= press[0];
      down_q <= press[1] || rep;
    end
  end

`ifdef SOFT_DROP_REPEAT_EN
  logic [TW-1:0] sd_tmr_q;
  logic          sd_das_q;
  // a repeat that would land on the release edge is dropped
  assign rep = !db_q[1] && !flip[1] && sd_tmr_q == (sd_das_q ? ARR_LIM : DAS_LIM);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sd_tmr_q <= '0;
      sd_das_q <= 1'b0;
    end else if (db_q[1] || rep) begin
      sd_tmr_q <= '0;
      sd_das_q <= !db_q[1];
    end else begin
      sd_tmr_q <= sd_tmr_q + 1'b1;
    end
  end
`else
  assign rep = 1'b0;
`endif

  assign io.move_left   = left_q;
  assign io.move_right  = right_q;
  assign io.move_down   = down_q;
  assign io.rotate      = rot_q;
  assign io.tilt_active = active_q;
endmodule

// File: tb/tb_tetris_input_ctrl.sv
// tb_tetris_input_ctrl: scoreboard bench; expected pulse cycles are queued at stimulus time and popped per pulse.
module tb_tetris_input_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  int q_l[$], q_r[$], q_d[$], q_rot[$];
  int t, u, p, r, acc;

  tetris_input_if bus();

  tetris_input_ctrl #(
    .HYST(40), .DB_CYCLES(4), .DAS_CYCLES(20), .ARR_CYCLES(8)
  ) dut (
    .clk(clk),
    .reset_n(rst_n),
    .io(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, int obs, int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
  endtask

  task automatic wait_until(int target);
    while (cyc < target) @(negedge clk);
  endtask

  function automatic int outs();
    return int'({bus.move_left, bus.move_right, bus.move_down, bus.rotate, bus.tilt_active});
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.move_right) chk("right_at", cyc, q_r.size() > 0 ? q_r.pop_front() : -1);
      if (bus.move_left)  chk("left_at", cyc, q_l.size() > 0 ? q_l.pop_front() : -1);
      if (bus.move_down)  chk("down_at", cyc, q_d.size() > 0 ? q_d.pop_front() : -1);
      if (bus.rotate)     chk("rotate_at", cyc, q_rot.size() > 0 ? q_rot.pop_front() : -1);
      if (bus.move_left && bus.move_right) chk("lr_exclusive", 1, 0);
    end
  end

  initial begin
    bus.adc_value = 12'd1650;
    bus.s1 = 1'b1;
    bus.s2 = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outs", outs(), 0);
    rst_n = 1'b1;
    acc = 0;
    repeat (100) begin
      @(negedge clk);
      acc |= outs();
    end
    chk("idle_outs", acc, 0);
    chk("idle_tilt_active", int'(bus.tilt_active), 0);

    t = cyc + 1;
    bus.adc_value = 12'd1900;
    foreach (q_r[i]) q_r.delete(i);
    q_r.push_back(t + 2);  q_r.push_back(t + 22); q_r.push_back(t + 30);
    q_r.push_back(t + 38); q_r.push_back(t + 46); q_r.push_back(t + 54);
    q_r.push_back(t + 62);
    wait_until(t + 1);
    chk("tilt_active_pre", int'(bus.tilt_active), 0);
    wait_until(t + 2);
    chk("tilt_active_on", int'(bus.tilt_active), 1);
    wait_until(t + 49);
    bus.adc_value = 12'd1790;
    wait_until(t + 63);
    bus.adc_value = 12'd1770;
    wait_until(t + 65);
    chk("tilt_active_hold", int'(bus.tilt_active), 1);
    wait_until(t + 66);
    chk("tilt_active_off", int'(bus.tilt_active), 0);
    wait_until(t + 90);
    chk("right_missing", q_r.size(), 0);

    t = cyc + 1;
    bus.adc_value = 12'd1900;
    q_r.push_back(t + 2);
    wait_until(t + 5);
    u = cyc + 1;
    bus.adc_value = 12'd1400;
    q_l.push_back(u + 2);
    wait_until(u + 10);
    bus.adc_value = 12'd1650;
    wait_until(u + 40);
    chk("swap_right_missing", q_r.size(), 0);
    chk("swap_left_missing", q_l.size(), 0);
    chk("swap_center", int'(bus.tilt_active), 0);

    p = cyc;
    bus.s1 = 1'b0;
    wait_until(p + 3);
    bus.s1 = 1'b1;
    wait_until(p + 30);
    p = cyc;
    bus.s1 = 1'b0;
    q_rot.push_back(p + 6);
    wait_until(p + 10);
    bus.s1 = 1'b1;
    wait_until(p + 40);
    chk("rotate_missing", q_rot.size(), 0);

    p = cyc;
    bus.s2 = 1'b0;
    q_d.push_back(p + 6);
`ifdef SOFT_DROP_REPEAT_EN
    q_d.push_back(p + 26); q_d.push_back(p + 34); q_d.push_back(p + 42);
    q_d.push_back(p + 50); q_d.push_back(p + 58);
`endif
    wait_until(p + 60);
    bus.s2 = 1'b1;
    wait_until(p + 90);
    chk("down_missing", q_d.size(), 0);

    p = cyc;
    bus.s2 = 1'b0;
    q_d.push_back(p + 6);
    wait_until(p + 6);
    #2 rst_n = 1'b0;
    #1 chk("reset_clears", outs(), 0);
    repeat (3) @(negedge clk);
    chk("reset_held_outs", outs(), 0);
    r = cyc;
    rst_n = 1'b1;
    q_d.push_back(r + 6);
    wait_until(r + 10);
    bus.s2 = 1'b1;
    wait_until(r + 40);
    chk("down_after_reset_missing", q_d.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
